// File: rtl/sar_search_pkg.sv
// sar_search_pkg: shared FSM states, comparator flag encoding and step-counter width
// for sar_search.
package sar_search_pkg;
    typedef enum logic [1:0] {IDLE, QUERY, UPDATE, DONE} state_t;
    localparam logic [2:0] FLAG_LT = 3'b100;
    localparam logic [2:0] FLAG_EQ = 3'b010;
    localparam logic [2:0] FLAG_GT = 3'b001;
    function automatic int STEP_W(input int width);
        return $clog2(width + 2);
    endfunction
endpackage

// File: rtl/sar_search.sv
// sar_search: binary-search initiator driving an external magnitude comparator.
// Define SAR_SEARCH_STEP_CNT_EN to add the steps output (comparator responses per search).
module sar_search
    import sar_search_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [WIDTH-1:0]           lo_bound,
    input  logic [WIDTH-1:0]           hi_bound,
    output logic [WIDTH-1:0]           guess,
    output logic                       guess_valid,
    input  logic                       cmp_valid,
    input  logic                       cmp_lt,
    input  logic                       cmp_eq,
    input  logic                       cmp_gt,
    output logic                       busy,
    output logic                       done,
    output logic                       found,
    output logic                       err,
    output logic [WIDTH-1:0]           result
`ifdef SAR_SEARCH_STEP_CNT_EN
    ,
    output logic [STEP_W(WIDTH)-1:0]   steps
`endif
);
    localparam logic [WIDTH:0] ONE = 1;
    state_t           r_state;
    logic [WIDTH:0]   r_lo, r_hi;
    logic [WIDTH-1:0] r_guess, r_result;
    logic [2:0]       r_flags;
    logic             r_guess_valid, r_busy, r_done, r_found, r_err;
    logic [WIDTH:0]   w_nlo, w_nhi;
    logic             w_stop;
    // (a+b)>>1 without losing the carry: halves summed plus the shared low bit.
    function automatic logic [WIDTH-1:0] mid(input logic [WIDTH:0] a, input logic [WIDTH:0] b);
        return a[WIDTH:1] + b[WIDTH:1] + {{(WIDTH-1){1'b0}}, a[0] & b[0]};
    endfunction
    always_comb begin
        w_nlo  = (r_flags == FLAG_LT) ? {1'b0, r_guess} + ONE : r_lo;
        w_nhi  = (r_flags == FLAG_LT) ? r_hi : {1'b0, r_guess} - ONE;
        // Range exhaustion is decided from the guess so neither bound has to over/underflow.
        w_stop = (r_flags == FLAG_LT) ? ({1'b0, r_guess} >= r_hi) : ({1'b0, r_guess} <= r_lo);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_lo          <= '0;
            r_hi          <= '0;
            r_guess       <= '0;
            r_result      <= '0;
            r_flags       <= '0;
            r_guess_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_found       <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (start) begin
                    r_lo     <= {1'b0, lo_bound};
                    r_hi     <= {1'b0, hi_bound};
                    r_guess  <= mid({1'b0, lo_bound}, {1'b0, hi_bound});
                    r_found  <= 1'b0;
                    r_err    <= 1'b0;
                    r_result <= '0;
                    if (lo_bound <= hi_bound) begin
                        r_state       <= QUERY;
                        r_guess_valid <= 1'b1;
                        r_busy        <= 1'b1;
                    end else begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                QUERY: if (cmp_valid) begin
                    r_flags       <= {cmp_lt, cmp_eq, cmp_gt};
                    r_guess_valid <= 1'b0;
                    r_state       <= UPDATE;
                end
                UPDATE: begin
                    r_lo <= w_nlo;
                    r_hi <= w_nhi;
                    if (r_flags == FLAG_EQ || (r_flags != FLAG_LT && r_flags != FLAG_GT) || w_stop) begin
                        r_found  <= (r_flags == FLAG_EQ);
                        r_result <= (r_flags == FLAG_EQ) ? r_guess : '0;
                        r_err    <= (r_flags != FLAG_EQ && r_flags != FLAG_LT && r_flags != FLAG_GT);
                        r_state  <= DONE;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                    end else begin
                        r_guess       <= mid(w_nlo, w_nhi);
                        r_guess_valid <= 1'b1;
                        r_state       <= QUERY;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign guess       = r_guess;
    assign guess_valid = r_guess_valid;
    assign busy        = r_busy;
    assign done        = r_done;
    assign found       = r_found;
    assign err         = r_err;
    assign result      = r_result;
`ifdef SAR_SEARCH_STEP_CNT_EN
    localparam logic [STEP_W(WIDTH)-1:0] STEP_ONE = 1;
    logic [STEP_W(WIDTH)-1:0] r_steps;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_steps <= '0;
        else if (r_state == IDLE && start) r_steps <= '0;
        else if (r_state == QUERY && cmp_valid) r_steps <= r_steps + STEP_ONE;
    end
    assign steps = r_steps;
`endif
endmodule

// File: tb/tb_sar_search.sv
// tb_sar_search: randomized scoreboard bench for sar_search; expected guesses and
// outcomes come from a plain integer binary-search model.
module tb_sar_search;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] lo_bound = '0, hi_bound = '0;
    logic [7:0] guess, result;
    logic       guess_valid, busy, done, found, err;
    logic       cmp_valid = 1'b0, cmp_lt = 1'b0, cmp_eq = 1'b0, cmp_gt = 1'b0;
`ifdef SAR_SEARCH_STEP_CNT_EN
    logic [sar_search_pkg::STEP_W(8)-1:0] steps;
`endif
    sar_search #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .lo_bound(lo_bound), .hi_bound(hi_bound),
        .guess(guess), .guess_valid(guess_valid), .cmp_valid(cmp_valid), .cmp_lt(cmp_lt),
        .cmp_eq(cmp_eq), .cmp_gt(cmp_gt), .busy(busy), .done(done), .found(found),
        .err(err), .result(result)
`ifdef SAR_SEARCH_STEP_CNT_EN
        , .steps(steps)
`endif
    );
    always #5 clk = ~clk;
    typedef struct {bit fnd; bit er; int res; int n;} exp_t;
    int   gq[$];
    exp_t rq[$];
    int   checks = 0, errors = 0;
    int   hidden = 0, stall = 0, nq = 0;
    bit   illegal = 0, noise = 0;
    function automatic void chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endfunction
    // Reference: textbook binary search over integers; hi may go to -1.
    function automatic void push_model(input int lo, input int hi, input int hid, input bit ill);
        exp_t e;
        int l = lo, h = hi, m;
        e = '{fnd: 0, er: 0, res: 0, n: 0};
        if (ill) begin
            if (l <= h) begin gq.push_back((l + h) / 2); e.n = 1; e.er = 1; end
        end else begin
            while (l <= h) begin
                m = (l + h) / 2;
                gq.push_back(m);
                e.n++;
                if (m == hid) begin e.fnd = 1; e.res = m; break; end
                else if (m < hid) l = m + 1;
                else h = m - 1;
            end
        end
        rq.push_back(e);
    endfunction
    // Comparator: optional stall, optional illegal flags, optional noise while idle.
    initial begin
        int w = 0;
        forever begin
            @(posedge clk); #1;
            cmp_valid = 1'b0;
            if (guess_valid) begin
                if (w < stall) w++;
                else begin
                    w = 0;
                    cmp_valid = 1'b1;
                    cmp_lt = illegal ? 1'b1 : (int'(guess) < hidden);
                    cmp_eq = illegal ? 1'b0 : (int'(guess) == hidden);
                    cmp_gt = illegal ? 1'b1 : (int'(guess) > hidden);
                end
            end else if (noise && $urandom_range(0, 1) == 1) begin
                cmp_valid = 1'b1;
                {cmp_lt, cmp_eq, cmp_gt} = 3'($urandom_range(0, 7));
            end
        end
    end
    // Monitor: pops expected guesses on each new query and outcomes on each done.
    initial begin
        bit pv = 0, pc = 0, pd = 0;
        int pg = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv = 0; pc = 0; pd = 0; nq = 0;
            end else begin
                if (guess_valid && !pv) begin
                    nq++;
                    chk("busy_in_query", busy, 1);
                    if (gq.size() == 0) chk("unexpected_query", 1, 0);
                    else chk("guess", guess, gq.pop_front());
                end
                if (guess_valid && pv) chk("guess_stable", guess, pg);
                if (pv && !guess_valid) chk("gv_drop_needs_resp", pc, 1);
                if (done) begin
                    chk("done_one_cycle", pd, 0);
                    chk("busy_at_done", busy, 0);
                    if (rq.size() == 0) chk("unexpected_done", 1, 0);
                    else begin
                        e = rq.pop_front();
                        chk("found", found, e.fnd);
                        chk("err", err, e.er);
                        chk("result", result, e.res);
                        chk("queries", nq, e.n);
`ifdef SAR_SEARCH_STEP_CNT_EN
                        chk("steps", steps, e.n);
`endif
                    end
                    nq = 0;
                end
                pv = guess_valid; pg = guess; pc = cmp_valid; pd = done;
            end
        end
    end
    task automatic run(input int lo, input int hi, input int hid, input int stl, input bit ill);
        int lat = 0;
        push_model(lo, hi, hid, ill);
        hidden = hid; stall = stl; illegal = ill;
        @(posedge clk); #1;
        lo_bound = 8'(lo); hi_bound = 8'(hi); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_clears_found", found, 0);
        chk("start_clears_err", err, 0);
        chk("start_clears_result", result, 0);
        chk("busy_after_start", busy, int'(lo <= hi));
        while (!done && lat < 300) begin @(posedge clk); #1; lat++; end
        chk("done_timeout", int'(done), 1);
        if (lo > hi) chk("empty_latency", lat, 0);
        illegal = 0;
    endtask
    initial begin
        int lo, hi, hid;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_guess", guess, 0);
        chk("rst_gv", guess_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_found", found, 0);
        chk("rst_err", err, 0);
        chk("rst_result", result, 0);
        rst_n = 1'b1;
        run(0, 255, 90, 0, 0);
        run(10, 20, 5, 0, 0);
        run(0, 0, -1, 0, 0);
        run(30, 20, 25, 0, 0);
        run(0, 255, 90, 0, 1);
        run(0, 255, 200, 0, 0);
        run(0, 255, 37, 5, 0);
        run(255, 255, 255, 0, 0);
        run(0, 255, 255, 1, 0);
        // Abort mid-search with an asynchronous reset; no done may follow.
        push_model(0, 255, 200, 0);
        hidden = 200; stall = 20;
        @(posedge clk); #1;
        lo_bound = 8'd0; hi_bound = 8'd255; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_gv", guess_valid, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_guess", guess, 0);
        chk("async_rst_done", done, 0);
        gq.delete(); rq.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        stall = 0;
        run(0, 255, 200, 0, 0);
        noise = 1;
        for (int i = 0; i < 40; i++) begin
            lo = $urandom_range(0, 255);
            hi = $urandom_range(0, 255);
            if (i % 4 != 0 && lo > hi) begin hid = lo; lo = hi; hi = hid; end
            hid = ($urandom_range(0, 3) != 0 && lo <= hi) ? $urandom_range(lo, hi) : $urandom_range(0, 255);
            run(lo, hi, hid, $urandom_range(0, 2), 0);
        end
        repeat (3) @(posedge clk);
        chk("scoreboard_drained", gq.size() + rq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
